// File: rtl/fifo_trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_trig_pkg
//  Description : Shared types and constants for the FIFO-occupancy watchdog.
//                - trig_state_t : trigger FSM states
//                - fifo_class_t : registered occupancy classification
//                - MODE_*       : output behaviour selectors
//                - sat_inc16    : saturating 16-bit increment
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_trig_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      FIRED   = 2'd2,
      REARM   = 2'd3
   } trig_state_t;

   typedef enum logic [1:0] {
      IN   = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } fifo_class_t;

   localparam int MODE_LEVEL = 0;
   localparam int MODE_PULSE = 1;
   localparam int MODE_ACK   = 2;

   // Event counter sticks at all-ones rather than wrapping to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_level_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_level_classifier
//  Description : Compares the FIFO word count against the window
//                [LOW_TH, HIGH_TH] and registers the result as IN/LOW/HIGH.
//                Also produces the combinational re-arm flag, which is true
//                when the current sample sits inside the window shrunk by
//                HYST_WORDS on both sides and neither FIFO flag is set.
//  Ports       : clk, reset (async, active-high)
//                fifo_full_i, fifo_empty_i, fifo_rd_data_count_i  - sample
//                class_o  - registered classification (1 cycle latency)
//                rearm_o  - combinational re-arm condition
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_level_classifier
   import fifo_trig_pkg::*;
#(
   parameter int unsigned COUNT_W    = 16,
   parameter int unsigned LOW_TH     = 2560,
   parameter int unsigned HIGH_TH    = 12800,
   parameter int unsigned HYST_WORDS = 64
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               fifo_full_i,
   input  logic               fifo_empty_i,
   input  logic [COUNT_W-1:0] fifo_rd_data_count_i,
   output fifo_class_t        class_o,
   output logic               rearm_o
);

   localparam logic [31:0] c_low_th   = 32'(LOW_TH);
   localparam logic [31:0] c_high_th  = 32'(HIGH_TH);
   localparam logic [31:0] c_rearm_lo = 32'(LOW_TH + HYST_WORDS);
   localparam logic [31:0] c_rearm_hi = 32'(HIGH_TH - HYST_WORDS);

   logic [31:0] w_count;
   fifo_class_t w_class_nxt;
   fifo_class_t r_class;

   // Zero-extend so every compare is a plain 32-bit unsigned compare.
   assign w_count = 32'(fifo_rd_data_count_i);

   // Full is checked first so a simultaneous full/empty reads as HIGH.
   // The thresholds themselves count as inside the window.
   always_comb begin
      w_class_nxt = IN;
      if (fifo_full_i || (w_count > c_high_th)) begin
         w_class_nxt = HIGH;
      end else if (fifo_empty_i || (w_count < c_low_th)) begin
         w_class_nxt = LOW;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_class <= IN;
      end else begin
         r_class <= w_class_nxt;
      end
   end

   assign class_o = r_class;
   assign rearm_o = (w_count >= c_rearm_lo) && (w_count <= c_rearm_hi) &&
                    !fifo_full_i && !fifo_empty_i;

endmodule
`default_nettype wire

// File: rtl/fifo_level_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_level_trigger
//  Description : FIFO-occupancy watchdog. Fires a trigger when the read-side
//                word count stays outside [LOW_TH, HIGH_TH] for
//                PERSIST_CYCLES consecutive registered samples, with re-arm
//                hysteresis, direction flags, a saturating event counter and
//                three output modes (level / single pulse / held until ack).
//  Ports       : clk, reset (async, active-high)
//                enable_i              - arm; 0 forces IDLE next cycle
//                fifo_full_i/empty_i   - FIFO flags
//                fifo_rd_data_count_i  - words available
//                trigger_ack_i         - acknowledge (ack mode only)
//                trigger_o             - registered trigger
//                trigger_high_o/low_o  - direction of the active trigger
//                event_count_o         - saturating count of fires
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_level_trigger
   import fifo_trig_pkg::*;
#(
   parameter int unsigned COUNT_W        = 16,
   parameter int unsigned FRAME_WORDS    = 1280,
   parameter int unsigned LOWER_FRAMES   = 2,
   parameter int unsigned UPPER_FRAMES   = 10,
   parameter int unsigned HYST_WORDS     = 64,
   parameter int unsigned PERSIST_CYCLES = 4,
   parameter int          MODE           = 0
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               enable_i,
   input  logic               fifo_full_i,
   input  logic               fifo_empty_i,
   input  logic [COUNT_W-1:0] fifo_rd_data_count_i,
   input  logic               trigger_ack_i,
   output logic               trigger_o,
   output logic               trigger_high_o,
   output logic               trigger_low_o,
   output logic [15:0]        event_count_o
);

   localparam int unsigned c_low_th  = FRAME_WORDS * LOWER_FRAMES;
   localparam int unsigned c_high_th = FRAME_WORDS * UPPER_FRAMES;
   localparam int          c_pw      = (PERSIST_CYCLES < 2) ? 1 : $clog2(PERSIST_CYCLES + 1);
   localparam logic [c_pw-1:0] c_persist_tgt = c_pw'(PERSIST_CYCLES);

   // ------------------------------------------------------------------------
   // Parameter sanity checks
   // ------------------------------------------------------------------------
   if (LOWER_FRAMES > UPPER_FRAMES) begin : g_err_frames
      $error("fifo_level_trigger: LOWER_FRAMES exceeds UPPER_FRAMES");
   end
   if ((c_low_th + 2 * HYST_WORDS) > c_high_th) begin : g_err_hyst
      $error("fifo_level_trigger: hysteresis wider than half the window");
   end
   if (PERSIST_CYCLES < 1) begin : g_err_persist
      $error("fifo_level_trigger: PERSIST_CYCLES must be at least 1");
   end
   if ((c_high_th >> COUNT_W) != 0) begin : g_err_width
      $error("fifo_level_trigger: HIGH_TH not representable in COUNT_W bits");
   end
   if ((MODE < MODE_LEVEL) || (MODE > MODE_ACK)) begin : g_err_mode
      $error("fifo_level_trigger: unsupported MODE");
   end

   // ------------------------------------------------------------------------
   // Classifier
   // ------------------------------------------------------------------------
   fifo_class_t w_class;
   logic        w_rearm;

   fifo_level_classifier #(
      .COUNT_W    (COUNT_W),
      .LOW_TH     (c_low_th),
      .HIGH_TH    (c_high_th),
      .HYST_WORDS (HYST_WORDS)
   ) u_classifier (
      .clk                  (clk),
      .reset                (reset),
      .fifo_full_i          (fifo_full_i),
      .fifo_empty_i         (fifo_empty_i),
      .fifo_rd_data_count_i (fifo_rd_data_count_i),
      .class_o              (w_class),
      .rearm_o              (w_rearm)
   );

   // ------------------------------------------------------------------------
   // Trigger FSM
   // ------------------------------------------------------------------------
   trig_state_t     r_state,       w_state_nxt;
   logic [c_pw-1:0] r_persist,     w_persist_nxt;
   logic            r_trigger,     w_trigger_nxt;
   logic            r_dir_high,    w_dir_high_nxt;
   logic [15:0]     r_event_count, w_event_count_nxt;
   logic [c_pw-1:0] w_persist_inc;
   logic            w_out;

   assign w_out         = (w_class != IN);
   assign w_persist_inc = r_persist + c_pw'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_persist     <= '0;
         r_trigger     <= 1'b0;
         r_dir_high    <= 1'b0;
         r_event_count <= 16'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_persist     <= w_persist_nxt;
         r_trigger     <= w_trigger_nxt;
         r_dir_high    <= w_dir_high_nxt;
         r_event_count <= w_event_count_nxt;
      end
   end

   // trigger_o is registered, so w_trigger_nxt describes the level wanted in
   // the state being entered. Entering FIRED always raises it for at least
   // one cycle, which is what lets an ack in the entry cycle take effect on
   // the following edge.
   always_comb begin
      w_state_nxt       = r_state;
      w_persist_nxt     = r_persist;
      w_trigger_nxt     = 1'b0;
      w_dir_high_nxt    = r_dir_high;
      w_event_count_nxt = r_event_count;

      if (!enable_i) begin
         w_state_nxt   = IDLE;
         w_persist_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_out) begin
                  if (PERSIST_CYCLES == 1) begin
                     w_state_nxt       = FIRED;
                     w_persist_nxt     = '0;
                     w_trigger_nxt     = 1'b1;
                     w_dir_high_nxt    = (w_class == HIGH);
                     w_event_count_nxt = sat_inc16(r_event_count);
                  end else begin
                     w_state_nxt   = PENDING;
                     w_persist_nxt = c_pw'(1);
                  end
               end
            end

            PENDING: begin
               // LOW->HIGH swaps keep counting; only a return to IN resets.
               if (w_out) begin
                  if (w_persist_inc == c_persist_tgt) begin
                     w_state_nxt       = FIRED;
                     w_persist_nxt     = '0;
                     w_trigger_nxt     = 1'b1;
                     w_dir_high_nxt    = (w_class == HIGH);
                     w_event_count_nxt = sat_inc16(r_event_count);
                  end else begin
                     w_persist_nxt = w_persist_inc;
                  end
               end else begin
                  w_state_nxt   = IDLE;
                  w_persist_nxt = '0;
               end
            end

            FIRED: begin
               if (MODE == MODE_ACK) begin
                  if (trigger_ack_i) begin
                     w_state_nxt = REARM;
                  end else begin
                     w_trigger_nxt = 1'b1;
                  end
               end else begin
                  if (w_rearm) begin
                     w_state_nxt = IDLE;
                  end else begin
                     w_trigger_nxt = (MODE == MODE_LEVEL);
                  end
               end
            end

            REARM: begin
               if (w_rearm) begin
                  w_state_nxt = IDLE;
               end
            end

            default: begin
               w_state_nxt   = IDLE;
               w_persist_nxt = '0;
            end
         endcase
      end
   end

   assign trigger_o      = r_trigger;
   assign trigger_high_o = r_trigger &  r_dir_high;
   assign trigger_low_o  = r_trigger & ~r_dir_high;
   assign event_count_o  = r_event_count;

endmodule
`default_nettype wire

// File: doc/fifo_level_trigger.md
Name: fifo_level_trigger

Overview:
Parametrised FIFO-occupancy watchdog; successor to the fixed-bound frame-window trigger. Compares the FIFO read-side word count against a frame-based window [LOW_TH, HIGH_TH] and fires a trigger when occupancy leaves the window.
Adds persistence filtering, re-arm hysteresis, direction flags, three output modes (level/pulse/handshake) and an event counter.
Sits beside the frame FIFO; trigger_o feeds the capture/flow-control logic downstream.

Parameters:
COUNT_W, 16, width of fifo_rd_data_count_i
FRAME_WORDS, 1280, words per frame
LOWER_FRAMES, 2, lower bound in frames; LOW_TH = FRAME_WORDS*LOWER_FRAMES
UPPER_FRAMES, 10, upper bound in frames; HIGH_TH = FRAME_WORDS*UPPER_FRAMES
HYST_WORDS, 64, re-arm hysteresis margin in words
PERSIST_CYCLES, 4, consecutive out-of-window samples required to fire (>=1)
MODE, 0, 0 = level, 1 = single-cycle pulse, 2 = held until ack

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable_i  in  1  arm/disarm the trigger
fifo_full_i  in  1  FIFO full flag
fifo_empty_i  in  1  FIFO empty flag
fifo_rd_data_count_i  in  COUNT_W  words available in the FIFO
trigger_ack_i  in  1  acknowledge; used only in MODE 2
trigger_o  out  1  trigger
trigger_high_o  out  1  fired due to over-range; valid while trigger_o=1
trigger_low_o  out  1  fired due to under-range; valid while trigger_o=1
event_count_o  out  16  number of fires, saturating

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-high. All outputs 0, state IDLE, persist counter 0, classifier register IN.
- Thresholds are elaboration constants, 32-bit unsigned; count is zero-extended before compare.
- Elaboration error if LOWER_FRAMES>UPPER_FRAMES, 2*HYST_WORDS>HIGH_TH-LOW_TH, PERSIST_CYCLES<1, or HIGH_TH>=2^COUNT_W.
- Classifier (registered, 1 cycle): HIGH if fifo_full_i or count>HIGH_TH; else LOW if fifo_empty_i or count<LOW_TH; else IN. Full wins over empty. Boundaries LOW_TH and HIGH_TH are IN.
- Re-arm condition (combinational on current sample): count>=LOW_TH+HYST_WORDS and count<=HIGH_TH-HYST_WORDS, and neither flag set.
- FSM states: IDLE, PENDING, FIRED, REARM.
  - IDLE: class OUT (HIGH or LOW) -> PENDING with persist=1; if PERSIST_CYCLES=1 -> FIRED directly.
  - PENDING: class OUT -> persist+1; reaching PERSIST_CYCLES -> FIRED. Class IN -> IDLE, persist=0. A HIGH/LOW direction change still counts as OUT.
  - FIRED: direction latched from the class at entry; event_count_o +1 (saturates at 0xFFFF).
    - MODE 0: trigger_o=1 for the whole of FIRED; re-arm -> IDLE.
    - MODE 1: trigger_o=1 on the first FIRED cycle only; re-arm -> IDLE.
    - MODE 2: trigger_o=1 until a cycle with trigger_ack_i=1, then -> REARM.
  - REARM: trigger_o=0; re-arm condition true -> IDLE.
- Latency: first out-of-window sample registered by the classifier at edge k; trigger_o rises at edge k+PERSIST_CYCLES (registered output).
- Direction flags equal the latched direction ANDed with trigger_o; both are never 1 together.
- Ack ordering (MODE 2): ack in the same cycle as FIRED entry is honoured at the next edge, so trigger_o is high for 1 cycle minimum. Ack outside FIRED is ignored.
- enable_i=0: synchronous return to IDLE; persist cleared; trigger/flags 0 next cycle. Classifier keeps running; event_count_o holds.
- Reset mid-FIRED: immediate return to reset values, event_count_o cleared.

Decomposition:
- Package fifo_trig_pkg: state enum (IDLE, PENDING, FIRED, REARM); class enum (IN, LOW, HIGH); mode constants MODE_LEVEL=0, MODE_PULSE=1, MODE_ACK=2.
- Sub-module fifo_level_classifier: threshold compare plus registered class output and re-arm flag.

Test Plan:
- Defaults, MODE 0: count 3000 steady, then 13000 from edge k -> trigger_o=1 and trigger_high_o=1 at edge k+4; event_count_o=1. Count 12800 -> stays high. Count 12700 -> trigger_o=0 next cycle.
- Defaults: count 2000 for 3 cycles then 3000 -> no trigger, FSM back to IDLE, event_count_o=0.
- MODE 1: fifo_empty_i=1 held 20 cycles -> exactly one 1-cycle pulse with trigger_low_o=1. A second empty episode after count 3000 -> second pulse, event_count_o=2.
- MODE 2: count 13000 -> trigger held; ack at cycle 10 -> low next edge. Count stays 13000 -> no re-fire until count 6000, then 13000 again -> re-fire.
- PERSIST_CYCLES=1, fifo_full_i and fifo_empty_i both 1 -> HIGH direction. enable_i=0 mid-FIRED -> trigger_o=0 next edge.
- Async reset asserted between edges while FIRED -> outputs 0 immediately; event count saturates at 0xFFFF after 65536 forced events.
